// File: rtl/store_monitor.sv
// Store monitor for the multi-cycle processor: logs every data-memory store into a
// first-word fall-through trace FIFO and delivers a sticky pass/fail/timeout verdict.
module store_monitor #(
    parameter logic [31:0] EXP_ADDR = 32'd84,
    parameter logic [31:0] EXP_DATA = 32'd7,
    parameter logic [31:0] IGN_ADDR = 32'd80,
    parameter int          TIMEOUT  = 50,
    parameter int          DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        overflow,
    output logic [15:0] store_cnt,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  fail_code
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_BAD_DATA = 2'b01;
    localparam logic [1:0] CODE_BAD_ADDR = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t        state, next_state;
    logic [1:0]    next_code;
    logic [CW-1:0] cycle_cnt;

    // ---------------- verdict FSM ----------------
    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_code  = fail_code;
        if (state == ST_RUN) begin
            if (memwrite && dataadr == EXP_ADDR) begin
                if (writedata == EXP_DATA) begin
                    next_state = ST_PASS;
                end else begin
                    next_state = ST_FAIL;
                    next_code  = CODE_BAD_DATA;
                end
            end else if (memwrite && dataadr != IGN_ADDR) begin
                next_state = ST_FAIL;
                next_code  = CODE_BAD_ADDR;
            end else if (cycle_cnt == LAST_CYCLE) begin
                // Store verdicts above take priority over a coincident timeout.
                next_state = ST_FAIL;
                next_code  = CODE_TIMEOUT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            fail_code <= CODE_NONE;
            cycle_cnt <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            fail_code <= next_code;
            if (state == ST_RUN)
                cycle_cnt <= cycle_cnt + 1'b1;
            pass <= (next_state == ST_PASS);
            fail <= (next_state == ST_FAIL);
            done <= (next_state != ST_RUN);
        end
    end

    // ---------------- trace FIFO ----------------
    logic [63:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rd_en && !empty;
    // A pop on the same edge frees the slot, so a store into a full FIFO is still kept.
    assign push  = memwrite && (!full || pop);

    assign rd_valid = !empty;
    assign rd_addr  = mem[rd_ptr[AW-1:0]][63:32];
    assign rd_data  = mem[rd_ptr[AW-1:0]][31:0];

    // NOTE: the storage array has no reset; only pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {dataadr, writedata};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            store_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (memwrite && !push)
                overflow <= 1'b1;
            if (memwrite && store_cnt != 16'hFFFF)
                store_cnt <= store_cnt + 16'd1;
        end
    end

endmodule

// File: doc/store_monitor.md
# store_monitor

Self-checking store monitor that sits directly downstream of the multi-cycle processor top. It samples the processor's data-memory write port (`memwrite`, `dataadr`, `writedata`) every clock and logs each store into a small drainable trace FIFO. It delivers a sticky pass/fail verdict against an expected result store, and flags a timeout if no verdict is reached within a cycle budget. It replaces ad-hoc fixed-cycle stop logic in benches and can also be synthesized for on-board self-test.

## Interface

Parameters:
- `EXP_ADDR`, 84: address of the result store.
- `EXP_DATA`, 7: required data for the store to `EXP_ADDR`.
- `IGN_ADDR`, 80: address whose stores are legal scratch writes and never trigger a verdict.
- `TIMEOUT`, 50: clock cycles after reset release allowed before a timeout fail. Must be ≥ 1.
- `DEPTH`, 8: trace FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `memwrite`  in  1  processor store strobe; one store per cycle it is high.
- `dataadr`  in  32  store byte address.
- `writedata`  in  32  store data.
- `rd_en`  in  1  pop request for the trace FIFO.
- `rd_valid`  out  1  FIFO not empty; head entry is presented (first-word fall-through).
- `rd_addr`  out  32  head entry address.
- `rd_data`  out  32  head entry data.
- `overflow`  out  1  sticky; at least one store was dropped because the FIFO was full.
- `store_cnt`  out  16  total stores observed; saturates at 16'hFFFF.
- `done`  out  1  verdict reached (PASS or FAIL state).
- `pass`  out  1  verdict is pass.
- `fail`  out  1  verdict is fail.
- `fail_code`  out  2  00 none, 01 wrong data at `EXP_ADDR`, 10 unexpected address, 11 timeout.

## Operation

- FSM states are RUN, PASS and FAIL. Reset enters RUN. PASS and FAIL are terminal until the next reset.
- In RUN, on each rising edge with `memwrite`=1, checks apply in this order:
  - `dataadr`==`EXP_ADDR` and `writedata`==`EXP_DATA`: go to PASS.
  - `dataadr`==`EXP_ADDR` with any other data: go to FAIL, code 01.
  - `dataadr`==`IGN_ADDR`: no verdict.
  - Any other address: go to FAIL, code 10.
- Timeout: a cycle counter of width $clog2(TIMEOUT+1) increments every edge while in RUN.
  - On the edge where the counter equals `TIMEOUT`-1 and no store verdict occurs, go to FAIL with code 11.
  - If a store verdict and the timeout fall on the same edge, the store verdict wins.
  - The counter freezes once the FSM leaves RUN.
- Trace logging is independent of the FSM. Every store is pushed as {`dataadr`,`writedata`}, in all states.
- FIFO rules:
  - Pop occurs when `rd_en`=1 and not empty. Pop when empty is ignored.
  - Push when full with a simultaneous pop: both are performed and the entry is kept.
  - Push when full without a pop: the entry is dropped and `overflow` is set.
  - Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. Full and empty are decoded from the MSB and the remaining pointer bits.
- `store_cnt` counts every store, including dropped ones, and saturates at 16'hFFFF.
- `pass`=(state==PASS), `fail`=(state==FAIL), `done`=`pass`|`fail`. All three are registered outputs.

## Timing

- Reset (`reset`=0) asynchronously clears the FSM to RUN, the cycle counter, both FIFO pointers, `overflow`, `store_cnt` and `fail_code`.
  - Output values during reset: `rd_valid`=0, `pass`=`fail`=`done`=0.
  - `rd_addr` and `rd_data` are don't-care while `rd_valid`=0.
- Reset mid-run discards all FIFO contents and any verdict. The timeout budget restarts at the first rising edge after `reset` returns to 1.
- Verdict latency: `pass`/`fail` are visible immediately after the edge that samples the deciding store, i.e. 1 cycle.
- Timeout `fail` is visible after exactly `TIMEOUT` rising edges following reset release.
- FIFO timing:
  - A stored entry appears at the head (`rd_valid`=1) after the push edge when the FIFO was empty.
  - A pop advances the head on the same edge.
  - Storage is register or RAM with asynchronous read; there is no read latency.
- `store_cnt` and `overflow` update on the sampling edge.

## Test plan

- Result store: release reset, then store (80,5) followed by (84,7) → `pass`=1 and `done`=1 after the (84,7) edge. `fail_code`=00, `store_cnt`=2, and the FIFO drains (80,5) then (84,7).
- Wrong data: store (84,3) → `fail`=1 and `fail_code`=01 on the next cycle. A later store (84,7) leaves the verdict unchanged, while `store_cnt` still increments.
- Unexpected address: store (88,7) → `fail`=1 and `fail_code`=10. Verify that a store to 80 alone never triggers a verdict.
- Timeout: no stores with `TIMEOUT`=50 → `fail`=1 and `fail_code`=11 after exactly 50 edges post-release. Also drive (84,7) on edge 50 → `pass`=1 instead of a timeout fail.
- FIFO overflow: with `DEPTH`=8 and `rd_en`=0, apply 9 consecutive stores → `overflow`=1, 8 entries are retained with the 9th dropped, and `store_cnt`=9. Then apply push and pop together while full → no drop and occupancy stays 8. A pop when empty leaves `rd_valid`=0.
- Async reset mid-run: after 3 stores, pulse `reset` low between clock edges → all outputs clear immediately, the FIFO is empty, and the timeout recounts from release.
